cipher_stream_arbiter: RTL and testbench

Sequential controller that shares one byte-wide key-addition cipher datapath between an encrypt requester and a decrypt requester. Messages are granted whole, round-robin. Each message is streamed one byte per cycle through a repeating key of SEC_LEN bytes. The block replaces per-message combinational encryptor/decryptor instances with a single time-multiplexed, handshaked stream.

---
 rtl/cipher_stream_arbiter.sv | 139 +++++++++++++
 tb/tb_cipher_stream_arbiter.sv | 316 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/cipher_stream_arbiter.sv
// cipher_stream_arbiter: round-robin arbiter that shares one byte-wide
// key-addition cipher between an encrypt and a decrypt requester.
// Ports: clk, rst_n (async, active low); key_we/key_idx/key_data write
// the SEC_LEN-byte key while idle; enc_*/dec_* are valid/ready byte
// streams with last; out_* is the registered result stream (out_dir
// 0 = encrypt, 1 = decrypt); busy = message in progress; trunc pulses
// when a message is cut at MSG_LEN bytes without last.
module cipher_stream_arbiter #(
   parameter int MSG_LEN = 20,
   parameter int SEC_LEN = 3,
   localparam int KW = ($clog2(SEC_LEN) > 1) ? $clog2(SEC_LEN) : 1,
   localparam int BW = ($clog2(MSG_LEN) > 1) ? $clog2(MSG_LEN) : 1
) (
   input  logic          clk,
   input  logic          rst_n,
   input  logic          key_we,
   input  logic [KW-1:0] key_idx,
   input  logic [7:0]    key_data,
   input  logic          enc_valid,
   input  logic [7:0]    enc_data,
   input  logic          enc_last,
   output logic          enc_ready,
   input  logic          dec_valid,
   input  logic [7:0]    dec_data,
   input  logic          dec_last,
   output logic          dec_ready,
   output logic          out_valid,
   input  logic          out_ready,
   output logic [7:0]    out_data,
   output logic          out_last,
   output logic          out_dir,
   output logic          busy,
   output logic          trunc
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_ENC,
      ST_DEC
   } state_e;

   state_e        state_q;
   logic          lg_dec_q;
   logic [KW-1:0] kidx_q;
   logic [KW-1:0] kidx_d;
   logic [BW-1:0] bcnt_q;
   logic [7:0]    key_q [SEC_LEN];
   logic          out_valid_q;
   logic [7:0]    out_data_q;
   logic          out_last_q;
   logic          out_dir_q;
   logic          trunc_q;

   logic       out_free;
   logic       is_dec;
   logic [7:0] in_data;
   logic       in_last;
   logic       accept;
   logic [7:0] key_b;
   logic [7:0] res;
   logic       msg_end;
   logic       grant_enc;

   // Output slot is free when empty or being drained this cycle.
   assign out_free  = !out_valid_q || out_ready;
   assign enc_ready = (state_q == ST_ENC) && out_free;
   assign dec_ready = (state_q == ST_DEC) && out_free;

   assign is_dec  = (state_q == ST_DEC);
   assign in_data = is_dec ? dec_data : enc_data;
   assign in_last = is_dec ? dec_last : enc_last;
   assign accept  = (enc_ready && enc_valid) || (dec_ready && dec_valid);

   assign key_b   = key_q[kidx_q];
   assign res     = is_dec ? (in_data - key_b) : (in_data + key_b);
   assign msg_end = in_last || (bcnt_q == BW'(MSG_LEN - 1));
   assign kidx_d  = (kidx_q == KW'(SEC_LEN - 1)) ? '0 : kidx_q + 1'b1;

   // Tie goes to the channel that was not served last.
   assign grant_enc = enc_valid && (!dec_valid || lg_dec_q);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= ST_IDLE;
         lg_dec_q    <= 1'b1;
         kidx_q      <= '0;
         bcnt_q      <= '0;
         out_valid_q <= 1'b0;
         out_data_q  <= '0;
         out_last_q  <= 1'b0;
         out_dir_q   <= 1'b0;
         trunc_q     <= 1'b0;
         for (int i = 0; i < SEC_LEN; i++) begin
            key_q[i] <= '0;
         end
      end else begin
         trunc_q <= 1'b0;
         if (out_valid_q && out_ready) begin
            out_valid_q <= 1'b0;
         end
         unique case (state_q)
            ST_IDLE: begin
               if (key_we && (int'(key_idx) < SEC_LEN)) begin
                  key_q[key_idx] <= key_data;
               end
               kidx_q <= '0;
               bcnt_q <= '0;
               if (enc_valid || dec_valid) begin
                  state_q <= grant_enc ? ST_ENC : ST_DEC;
               end
            end
            ST_ENC, ST_DEC: begin
               if (accept) begin
                  out_valid_q <= 1'b1;
                  out_data_q  <= res;
                  out_last_q  <= msg_end;
                  out_dir_q   <= is_dec;
                  kidx_q      <= kidx_d;
                  bcnt_q      <= bcnt_q + 1'b1;
                  if (msg_end) begin
                     state_q  <= ST_IDLE;
                     lg_dec_q <= is_dec;
                     trunc_q  <= !in_last;
                  end
               end
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign out_valid = out_valid_q;
   assign out_data  = out_data_q;
   assign out_last  = out_last_q;
   assign out_dir   = out_dir_q;
   assign busy      = (state_q != ST_IDLE);
   assign trunc     = trunc_q;

endmodule

// File: tb/tb_cipher_stream_arbiter.sv
// Testbench for cipher_stream_arbiter: directed and random streams
// checked against a per-channel byte/key-position reference model.
module tb_cipher_stream_arbiter;

   localparam int MSG_LEN = 20;
   localparam int SEC_LEN = 3;
   localparam int KW = 2;

   logic          clk = 1'b0;
   logic          rst_n;
   logic          key_we;
   logic [KW-1:0] key_idx;
   logic [7:0]    key_data;
   logic          enc_valid, enc_last, enc_ready;
   logic [7:0]    enc_data;
   logic          dec_valid, dec_last, dec_ready;
   logic [7:0]    dec_data;
   logic          out_valid, out_ready, out_last, out_dir;
   logic [7:0]    out_data;
   logic          busy, trunc;

   cipher_stream_arbiter #(.MSG_LEN(MSG_LEN), .SEC_LEN(SEC_LEN)) dut (
      .clk(clk), .rst_n(rst_n),
      .key_we(key_we), .key_idx(key_idx), .key_data(key_data),
      .enc_valid(enc_valid), .enc_data(enc_data),
      .enc_last(enc_last), .enc_ready(enc_ready),
      .dec_valid(dec_valid), .dec_data(dec_data),
      .dec_last(dec_last), .dec_ready(dec_ready),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_data(out_data), .out_last(out_last), .out_dir(out_dir),
      .busy(busy), .trunc(trunc)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [7:0] d;
      logic       l;
      logic       dir;
   } exp_t;

   int   tests = 0;
   int   fails = 0;
   int   cyc = 0;
   int   hs_cnt = 0;
   int   trunc_cnt = 0;
   int   trunc_exp = 0;
   int   mpos [2];
   logic [7:0] keym [SEC_LEN];
   exp_t sb [$];
   int   hs_t [$];
   int   hs_dir [$];
   exp_t mon_e;
   int   drv_done;

   task automatic check(input string tag, input logic [31:0] got,
                        input logic [31:0] exp);
      tests++;
      assert (got === exp) else begin
         fails++;
         $error("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference: byte at message position p uses key[p mod SEC_LEN];
   // a message ends on last or after MSG_LEN bytes.
   function automatic void model_accept(input bit dir, input logic [7:0] d,
                                        input bit lst);
      exp_t e;
      int   p;
      p     = mpos[dir];
      e.d   = dir ? 8'(d - keym[p % SEC_LEN]) : 8'(d + keym[p % SEC_LEN]);
      e.l   = lst || (p == MSG_LEN - 1);
      e.dir = dir;
      if (e.l && !lst) trunc_exp++;
      mpos[dir] = e.l ? 0 : p + 1;
      sb.push_back(e);
   endfunction

   always @(posedge clk) cyc++;

   always @(negedge clk) begin
      #2;
      if (rst_n) begin
         if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
               check("unexpected_byte", {out_dir, out_data}, 32'hFFFF);
            end else begin
               mon_e = sb.pop_front();
               check("out_data", out_data, mon_e.d);
               check("out_last", out_last, mon_e.l);
               check("out_dir", out_dir, mon_e.dir);
            end
            hs_cnt++;
            hs_t.push_back(cyc);
            hs_dir.push_back(int'(out_dir));
         end
         if (trunc) begin
            trunc_cnt++;
            check("trunc_align", {out_valid, out_last}, 2'b11);
         end
         check("ready_excl", enc_ready && dec_ready, 0);
         if (enc_ready || dec_ready) check("ready_busy", busy, 1);
      end
   end

   task automatic send(input bit dir, input logic [7:0] d[$],
                       input bit set_last, input int gapmax);
      int cnt;
      bit acc;
      bit lst;
      for (int i = 0; i < d.size(); i++) begin
         lst = set_last && (i == d.size() - 1);
         repeat ($urandom_range(gapmax, 0)) @(negedge clk);
         if (dir) begin
            dec_valid = 1'b1; dec_data = d[i]; dec_last = lst;
         end else begin
            enc_valid = 1'b1; enc_data = d[i]; enc_last = lst;
         end
         cnt = 0;
         acc = 1'b0;
         while (!acc && cnt < 300) begin
            #1;
            acc = dir ? dec_ready : enc_ready;
            if (acc) model_accept(dir, d[i], lst);
            @(negedge clk);
            cnt++;
         end
         check("accept_timeout", acc, 1);
         if (dir) begin
            dec_valid = 1'b0; dec_last = 1'b0;
         end else begin
            enc_valid = 1'b0; enc_last = 1'b0;
         end
      end
      drv_done++;
   endtask

   task automatic wkey(input int idx, input logic [7:0] v);
      key_we = 1'b1; key_idx = KW'(idx); key_data = v;
      @(negedge clk);
      key_we = 1'b0;
      if (idx < SEC_LEN) keym[idx] = v;
   endtask

   task automatic drain();
      int n;
      n = 0;
      while (sb.size() != 0 && n < 200) begin
         @(negedge clk);
         n++;
      end
      @(negedge clk);
      check("drain", sb.size(), 0);
   endtask

   task automatic wait_hs(input int target);
      int n;
      n = 0;
      while (hs_cnt < target && n < 200) begin
         @(negedge clk);
         n++;
      end
      check("wait_hs", hs_cnt >= target, 1);
   endtask

   initial begin
      logic [7:0] qa [$];
      logic [7:0] qb [$];
      logic [7:0] hd;
      logic       hl;
      int base, t0;
      rst_n = 1'b0; key_we = 1'b0; key_idx = '0; key_data = '0;
      enc_valid = 1'b0; enc_data = '0; enc_last = 1'b0;
      dec_valid = 1'b0; dec_data = '0; dec_last = 1'b0;
      out_ready = 1'b1;
      mpos[0] = 0; mpos[1] = 0;
      for (int i = 0; i < SEC_LEN; i++) keym[i] = '0;
      repeat (2) @(negedge clk);
      check("rst_out_valid", out_valid, 0);
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_vals", {out_valid, out_last, out_dir, busy, trunc}, 0);
      check("rst_data", out_data, 0);
      check("rst_ready", {enc_ready, dec_ready}, 0);

      // Encrypt with key {3,5,7}; index 3 write is out of range.
      wkey(0, 8'd3); wkey(1, 8'd5); wkey(2, 8'd7); wkey(3, 8'd9);
      base = hs_cnt;
      qa = {8'h41, 8'h41, 8'h42, 8'h42};
      send(0, qa, 1, 0);
      drain();
      check("enc_count", hs_cnt - base, 4);
      check("enc_rate", hs_t[base+3] - hs_t[base], 3);

      // Decrypt round trip.
      qa = {8'h44, 8'h46, 8'h49, 8'h45};
      send(1, qa, 1, 0);
      drain();

      // Modular wrap.
      wkey(0, 8'd5); wkey(1, 8'd0); wkey(2, 8'd0);
      qa = {8'hFE};
      send(0, qa, 1, 0);
      qa = {8'h03};
      send(1, qa, 1, 0);
      drain();

      // Backpressure for three cycles mid-message.
      wkey(0, 8'd3); wkey(1, 8'd5); wkey(2, 8'd7);
      base = hs_cnt;
      qa = {8'h10, 8'h20, 8'h30, 8'h40, 8'h50, 8'h60};
      fork
         send(0, qa, 1, 0);
         begin
            wait_hs(base + 2);
            out_ready = 1'b0;
            #1;
            hd = out_data;
            hl = out_last;
            check("bp_valid", out_valid, 1);
            for (int j = 0; j < 3; j++) begin
               check("bp_ready", enc_ready, 0);
               check("bp_data", out_data, hd);
               check("bp_last", out_last, hl);
               @(negedge clk);
               #1;
            end
            @(negedge clk);
            out_ready = 1'b1;
         end
      join
      drain();
      check("bp_count", hs_cnt - base, 6);

      // Truncation: 21 bytes without last, then close the second message.
      t0 = trunc_cnt;
      qa.delete();
      for (int i = 0; i < 21; i++) qa.push_back(8'($urandom));
      send(0, qa, 0, 0);
      qa = {8'h11};
      send(0, qa, 1, 0);
      drain();
      check("trunc_pulse", trunc_cnt - t0, 1);

      // Reset mid-message.
      out_ready = 1'b0;
      enc_valid = 1'b1; enc_data = 8'h55; enc_last = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("mid_valid", out_valid, 1);
      check("mid_busy", busy, 1);
      rst_n = 1'b0;
      #1;
      check("rst_async_valid", out_valid, 0);
      check("rst_async_busy", busy, 0);
      enc_valid = 1'b0;
      @(negedge clk);
      rst_n = 1'b1;
      out_ready = 1'b1;
      mpos[0] = 0; mpos[1] = 0;
      for (int i = 0; i < SEC_LEN; i++) keym[i] = '0;
      @(negedge clk);

      // Arbitration ties out of reset: enc first both times.
      wkey(0, 8'd1); wkey(1, 8'd2); wkey(2, 8'd3);
      for (int r = 0; r < 2; r++) begin
         base = hs_cnt;
         qa = {8'($urandom), 8'($urandom)};
         qb = {8'($urandom), 8'($urandom)};
         drv_done = 0;
         fork
            send(0, qa, 1, 0);
            send(1, qb, 1, 0);
         join
         drain();
         check("tie_first", hs_dir[base], 0);
         check("tie_second", hs_dir[base+1], 0);
         check("tie_third", hs_dir[base+2], 1);
         check("tie_gap", hs_t[base+2] - hs_t[base+1], 2);
      end

      // Random traffic with random backpressure and gaps.
      for (int it = 0; it < 25; it++) begin
         wkey($urandom_range(3, 0), 8'($urandom));
         qa.delete();
         qb.delete();
         repeat ($urandom_range(24, 1)) qa.push_back(8'($urandom));
         repeat ($urandom_range(24, 1)) qb.push_back(8'($urandom));
         drv_done = 0;
         fork
            send(0, qa, 1, 2);
            send(1, qb, 1, 2);
            begin
               while (drv_done < 2) begin
                  @(negedge clk);
                  out_ready = ($urandom_range(3, 0) != 0);
               end
               out_ready = 1'b1;
            end
         join
         drain();
      end
      check("trunc_total", trunc_cnt, trunc_exp);

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

   initial begin
      #500000;
      $display("FAIL timeout: bench did not finish");
      $fatal(1, "timeout");
   end

endmodule
